// File: rtl/fft_peak_picker.sv
// fft_peak_picker: tracks the strongest positive-frequency bin (re^2+im^2) of each streamed FFT frame
module fft_peak_picker #(
  parameter int NFFT       = 1024,
  parameter int DATA_W     = 8,
  parameter int MIN_BIN    = 2,
  parameter int MAG_THRESH = 64
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic [2*DATA_W-1:0]       fft_data_in,
  input  logic                      fft_valid_in,
  input  logic                      fft_last_in,
  output logic                      fft_ready_out,
  output logic [$clog2(NFFT)-1:0]   peak_bin_out,
  output logic [2*DATA_W:0]         peak_mag_out,
  output logic                      peak_present_out,
  output logic                      peak_valid_out,
  output logic                      frame_err_out
);
  localparam int BW = $clog2(NFFT);
  localparam int PW = 2 * DATA_W;
  localparam int MW = 2 * DATA_W + 1;
  localparam logic [1:0] ACCUM = 2'd0, DRAIN = 2'd1, REPORT = 2'd2;
  localparam logic [BW-1:0] LO_BIN = BW'(MIN_BIN), HI_BIN = BW'(NFFT / 2 - 1), END_BIN = BW'(NFFT - 1);
  localparam logic [MW-1:0] THRESH = MW'(MAG_THRESH);
  logic [1:0] state;
  logic drain_cnt, err;
  logic [BW-1:0] cnt, s1_bin, s2_bin, max_bin;
  logic [PW-1:0] re2, im2;
  logic [MW-1:0] s2_mag, max_mag;
  logic s1_v, s2_v, acc, frame_end, in_range;
  logic signed [PW-1:0] re, im;
  assign re = {{DATA_W{fft_data_in[PW-1]}}, fft_data_in[PW-1:DATA_W]};
  assign im = {{DATA_W{fft_data_in[DATA_W-1]}}, fft_data_in[DATA_W-1:0]};
  assign fft_ready_out = state == ACCUM;
  assign acc = fft_valid_in && fft_ready_out;
  assign frame_end = acc && (fft_last_in || cnt == END_BIN);
  assign in_range = s2_bin >= LO_BIN && s2_bin <= HI_BIN;
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state <= ACCUM;
      drain_cnt <= 1'b0;
      err <= 1'b0;
      cnt <= '0;
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_bin <= '0;
      s2_bin <= '0;
      re2 <= '0;
      im2 <= '0;
      s2_mag <= '0;
      max_mag <= '0;
      max_bin <= '0;
      peak_bin_out <= '0;
      peak_mag_out <= '0;
      peak_present_out <= 1'b0;
      peak_valid_out <= 1'b0;
      frame_err_out <= 1'b0;
    end else begin
      s1_v <= acc;
      if (acc) begin
        re2 <= re * re;
        im2 <= im * im;
        s1_bin <= cnt;
      end
      s2_v <= s1_v;
      s2_mag <= {1'b0, re2} + {1'b0, im2};
      s2_bin <= s1_bin;
      // strictly greater so that ties keep the earlier (lower) bin
      if (s2_v && in_range && s2_mag > max_mag) begin
        max_mag <= s2_mag;
        max_bin <= s2_bin;
      end
      peak_valid_out <= 1'b0;
      frame_err_out <= 1'b0;
      case (state)
        ACCUM: begin
          if (acc) cnt <= cnt + 1'b1;
          if (frame_end) begin
            state <= DRAIN;
            drain_cnt <= 1'b0;
            err <= !(fft_last_in && cnt == END_BIN);
          end
        end
        DRAIN: begin
          drain_cnt <= 1'b1;
          if (drain_cnt) state <= REPORT;
        end
        default: begin
          peak_bin_out <= max_bin;
          peak_mag_out <= max_mag;
          peak_present_out <= max_mag >= THRESH;
          peak_valid_out <= 1'b1;
          frame_err_out <= err;
          max_mag <= '0;
          max_bin <= '0;
          cnt <= '0;
          state <= ACCUM;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_fft_peak_picker.sv
// tb_fft_peak_picker: randomized frames checked against a per-frame argmax reference model
module tb_fft_peak_picker;
  localparam int NFFT = 1024;
  logic clk_in = 1'b0, rst_in = 1'b0;
  logic [15:0] fft_data_in = '0;
  logic fft_valid_in = 1'b0, fft_last_in = 1'b0;
  logic fft_ready_out, peak_present_out, peak_valid_out, frame_err_out;
  logic [9:0] peak_bin_out;
  logic [16:0] peak_mag_out;
  int tests = 0, fails = 0;
  int fre[NFFT], fim[NFFT];
  int exp_bin = 0, exp_mag = 0;

  fft_peak_picker dut (
    .clk_in(clk_in), .rst_in(rst_in), .fft_data_in(fft_data_in), .fft_valid_in(fft_valid_in),
    .fft_last_in(fft_last_in), .fft_ready_out(fft_ready_out), .peak_bin_out(peak_bin_out),
    .peak_mag_out(peak_mag_out), .peak_present_out(peak_present_out),
    .peak_valid_out(peak_valid_out), .frame_err_out(frame_err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic clear_frame();
    for (int i = 0; i < NFFT; i++) begin
      fre[i] = 0;
      fim[i] = 0;
    end
  endtask

  task automatic random_frame();
    for (int i = 0; i < NFFT; i++) begin
      fre[i] = int'($urandom_range(255)) - 128;
      fim[i] = int'($urandom_range(255)) - 128;
    end
  endtask

  task automatic run_frame(input string name, input int len, input bit use_last, input int bub);
    int m, lat, low, notrdy, eb, em;
    bit ee;
    logic [9:0] gb;
    logic [16:0] gm;
    logic gp, ge;
    lat = -1; low = 0; notrdy = 0; eb = 0; em = 0;
    gb = '0; gm = '0; gp = 1'b0; ge = 1'b0;
    for (int i = 0; i < len; i++) begin
      while (int'($urandom_range(99)) < bub) begin
        fft_valid_in = 1'b0;
        fft_data_in = 16'($urandom);
        fft_last_in = 1'($urandom);
        @(posedge clk_in); #1;
      end
      if (!fft_ready_out) notrdy++;
      fft_valid_in = 1'b1;
      fft_data_in = {fre[i][7:0], fim[i][7:0]};
      fft_last_in = use_last && i == len - 1;
      @(posedge clk_in); #1;
      m = fre[i] * fre[i] + fim[i] * fim[i];
      if (i >= 2 && i <= NFFT / 2 - 1 && m > em) begin
        em = m;
        eb = i;
      end
    end
    fft_valid_in = 1'b0;
    fft_last_in = 1'b0;
    ee = !(use_last && len == NFFT);
    if (!fft_ready_out) low++;
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge clk_in); #1;
      if (!fft_ready_out) low++;
      if (peak_valid_out) begin
        lat = c;
        gb = peak_bin_out;
        gm = peak_mag_out;
        gp = peak_present_out;
        ge = frame_err_out;
      end
    end
    exp_bin = eb;
    exp_mag = em;
    tests++; if (lat !== 3) begin fails++; $display("FAIL %s valid_latency: got %0d want 3", name, lat); end
    tests++; if (low !== 3) begin fails++; $display("FAIL %s ready_low_cycles: got %0d want 3", name, low); end
    tests++; if (notrdy !== 0) begin fails++; $display("FAIL %s ready_during_frame: %0d beats not ready, want 0", name, notrdy); end
    tests++; if (int'(gb) !== eb) begin fails++; $display("FAIL %s peak_bin: got %0d want %0d", name, gb, eb); end
    tests++; if (int'(gm) !== em) begin fails++; $display("FAIL %s peak_mag: got %0d want %0d", name, gm, em); end
    tests++; if (gp !== (em >= 64)) begin fails++; $display("FAIL %s peak_present: got %b want %b", name, gp, em >= 64); end
    tests++; if (ge !== ee) begin fails++; $display("FAIL %s frame_err: got %b want %b", name, ge, ee); end
    @(posedge clk_in); #1;
    tests++; if (peak_valid_out !== 1'b0) begin fails++; $display("FAIL %s valid_pulse_width: got %b want 0", name, peak_valid_out); end
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    tests++; if ({peak_valid_out, frame_err_out, peak_present_out} !== 3'b000) begin fails++; $display("FAIL reset_flags: got %b want 000", {peak_valid_out, frame_err_out, peak_present_out}); end
    tests++; if (peak_bin_out !== 10'd0 || peak_mag_out !== 17'd0) begin fails++; $display("FAIL reset_peak: got bin %0d mag %0d want 0 0", peak_bin_out, peak_mag_out); end
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    tests++; if (fft_ready_out !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", fft_ready_out); end
  endtask

  task automatic test_single_peak();
    clear_frame();
    fre[10] = 50;
    run_frame("single_peak", NFFT, 1'b1, 0);
  endtask

  task automatic test_tie();
    clear_frame();
    fre[5] = 30; fim[5] = 40;
    fre[9] = 30; fim[9] = 40;
    run_frame("tie", NFFT, 1'b1, 10);
  endtask

  task automatic test_range();
    clear_frame();
    fre[1] = 127; fim[1] = 127;
    fre[600] = 127; fim[600] = 127;
    fre[20] = 10;
    run_frame("range", NFFT, 1'b1, 0);
    clear_frame();
    fre[511] = 20;
    fre[512] = 100;
    fre[0] = -100;
    run_frame("range_edge", NFFT, 1'b1, 5);
  endtask

  task automatic test_extremes();
    clear_frame();
    fre[7] = -128; fim[7] = -128;
    run_frame("max_mag", NFFT, 1'b1, 0);
    clear_frame();
    fre[3] = 4; fim[3] = 4;
    run_frame("below_thresh", NFFT, 1'b1, 0);
    clear_frame();
    run_frame("no_peak", NFFT, 1'b1, 0);
  endtask

  task automatic test_frame_err();
    clear_frame();
    fre[10] = 50;
    run_frame("short_frame", 100, 1'b1, 0);
    clear_frame();
    fre[12] = 60;
    run_frame("after_short", NFFT, 1'b1, 0);
    clear_frame();
    fre[300] = -70; fim[300] = 3;
    run_frame("no_last", NFFT, 1'b0, 0);
  endtask

  task automatic test_hold();
    repeat (15) @(posedge clk_in);
    #1;
    tests++; if (int'(peak_bin_out) !== exp_bin || int'(peak_mag_out) !== exp_mag) begin fails++; $display("FAIL hold: got bin %0d mag %0d want %0d %0d", peak_bin_out, peak_mag_out, exp_bin, exp_mag); end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      random_frame();
      run_frame("random", NFFT, 1'b1, 25);
    end
  endtask

  task automatic test_back_to_back();
    random_frame();
    run_frame("b2b_a", NFFT, 1'b1, 0);
    random_frame();
    run_frame("b2b_b", 300, 1'b1, 0);
  endtask

  task automatic test_reset_mid_frame();
    int pulses;
    random_frame();
    for (int i = 0; i < 500; i++) begin
      while (int'($urandom_range(99)) < 20) begin
        fft_valid_in = 1'b0;
        @(posedge clk_in); #1;
      end
      fft_valid_in = 1'b1;
      fft_data_in = {fre[i][7:0], fim[i][7:0]};
      fft_last_in = 1'b0;
      @(posedge clk_in); #1;
    end
    fft_valid_in = 1'b0;
    rst_in = 1'b0;
    #2;
    tests++; if (peak_valid_out !== 1'b0 || peak_mag_out !== 17'd0) begin fails++; $display("FAIL midreset_outputs: got valid %b mag %0d want 0 0", peak_valid_out, peak_mag_out); end
    @(posedge clk_in); #2;
    rst_in = 1'b1;
    pulses = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk_in); #1;
      if (peak_valid_out) pulses++;
    end
    tests++; if (pulses !== 0) begin fails++; $display("FAIL midreset_no_pulse: got %0d pulses want 0", pulses); end
    tests++; if (fft_ready_out !== 1'b1) begin fails++; $display("FAIL midreset_ready: got %b want 1", fft_ready_out); end
    clear_frame();
    fre[10] = 50;
    run_frame("after_midreset", NFFT, 1'b1, 15);
  endtask

  initial begin
    test_reset();
    test_single_peak();
    test_hold();
    test_tie();
    test_range();
    test_extremes();
    test_frame_err();
    test_random();
    test_back_to_back();
    test_reset_mid_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
